// File: rtl/tcore_param.sv
// rtl/tcore_param.sv - shared tcore parameters and memory-arbiter types
package tcore_param;

  localparam int MEM_ARB_NUM_REQ = 2;   // icache=0, dcache=1
  localparam int MEM_ARB_ADDR_W  = 32;
  localparam int MEM_ARB_BLK_W   = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [MEM_ARB_ADDR_W-1:0]   addr;
    logic [MEM_ARB_BLK_W/8-1:0]  wstrb;
    logic [MEM_ARB_BLK_W-1:0]    wdata;
  } mem_blk_req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin picker
// First set valid bit strictly after i_last, wrapping; o_any=0 when nothing is valid.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int               w_pos;
  logic [IDX_W-1:0] w_sel;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    w_sel   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = int'(i_last) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_sel = IDX_W'(w_pos);
      if (!o_any && i_valid[w_sel]) begin
        o_any          = 1'b1;
        o_idx          = w_sel;
        o_grant[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port round-robin arbiter onto the single block memory port
// Define MEM_ARB_TIMEOUT_EN to add a forced error completion after TIMEOUT_CYC busy cycles.
module mem_arbiter_rr
  import tcore_param::*;
#(
  parameter int NUM_REQ     = MEM_ARB_NUM_REQ,
  parameter int ADDR_W      = MEM_ARB_ADDR_W,
  parameter int BLK_W       = MEM_ARB_BLK_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][BLK_W/8-1:0] req_wstrb_i,
  input  logic [NUM_REQ-1:0][BLK_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              res_valid_o,
  output logic [BLK_W-1:0]                res_rdata_o,
  output logic                            res_err_o,
  output logic                            mem_req_valid_o,
  output logic [ADDR_W-1:0]               mem_req_addr_o,
  output logic [BLK_W/8-1:0]              mem_req_wstrb_o,
  output logic [BLK_W-1:0]                mem_req_wdata_o,
  input  logic                            mem_ready_i,
  input  logic [BLK_W-1:0]                mem_rdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_owner;
  mem_blk_req_t     r_req;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_accept;
  logic               w_done_mem;
  logic               w_tmo_hit;
  logic               w_done;
  logic [NUM_REQ-1:0] w_owner_oh;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_valid (req_valid_i),
    .i_last  (r_last_grant),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_accept   = (r_state == IDLE) && w_pick_any;
  assign w_done_mem = (r_state == BUSY) && mem_ready_i;
  assign w_done     = w_done_mem || w_tmo_hit;
  assign w_owner_oh = NUM_REQ'(1) << r_owner;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == BUSY) && !mem_ready_i) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // A real completion in the expiry cycle takes precedence over the timeout.
  assign w_tmo_hit = (r_state == BUSY) && !mem_ready_i &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = (TIMEOUT_CYC > 0);
  assign w_tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_req        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state     <= BUSY;
            r_owner     <= w_pick_idx;
            r_req.addr  <= req_addr_i[w_pick_idx];
            r_req.wstrb <= req_wstrb_i[w_pick_idx];
            r_req.wdata <= req_wdata_i[w_pick_idx];
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state      <= IDLE;
            r_last_grant <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gate with reset so a held valid cannot show a grant while reset is asserted.
  assign req_ready_o     = (rst_ni && w_accept) ? w_pick_grant : '0;
  assign res_valid_o     = w_done ? w_owner_oh : '0;
  assign res_rdata_o     = w_done_mem ? mem_rdata_i : '0;
  assign res_err_o       = w_tmo_hit;
  assign mem_req_valid_o = (r_state == BUSY);
  assign mem_req_addr_o  = r_req.addr;
  assign mem_req_wstrb_o = r_req.wstrb;
  assign mem_req_wdata_o = r_req.wdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - scoreboard bench for mem_arbiter_rr
module tb_mem_arbiter_rr;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int BW = 128;
  localparam int SW = BW / 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_valid_i;
  logic [N-1:0][AW-1:0]  req_addr_i;
  logic [N-1:0][SW-1:0]  req_wstrb_i;
  logic [N-1:0][BW-1:0]  req_wdata_i;
  logic [N-1:0]          req_ready_o;
  logic [N-1:0]          res_valid_o;
  logic [BW-1:0]         res_rdata_o;
  logic                  res_err_o;
  logic                  mem_req_valid_o;
  logic [AW-1:0]         mem_req_addr_o;
  logic [SW-1:0]         mem_req_wstrb_o;
  logic [BW-1:0]         mem_req_wdata_o;
  logic                  mem_ready_i;
  logic [BW-1:0]         mem_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .BLK_W       (BW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid_i),
    .req_addr_i      (req_addr_i),
    .req_wstrb_i     (req_wstrb_i),
    .req_wdata_i     (req_wdata_i),
    .req_ready_o     (req_ready_o),
    .res_valid_o     (res_valid_o),
    .res_rdata_o     (res_rdata_o),
    .res_err_o       (res_err_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wstrb_o (mem_req_wstrb_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_ready_i     (mem_ready_i),
    .mem_rdata_i     (mem_rdata_i)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] wstrb;
    logic [BW-1:0] wdata;
    bit            wiggle;
  } req_t;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [SW-1:0] wstrb;
    logic [BW-1:0] wdata;
    int            lat;
    logic          err;
    logic [BW-1:0] rdata;
  } txn_t;

  req_t pq[N][$];
  txn_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int mem_lat = 1;
  bit mem_en  = 1'b0;
  bit drv_en  = 1'b0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, req);
  endtask

  function automatic logic [BW-1:0] rdata_for(input logic [AW-1:0] a);
    return {32'hDEAD_0000, a, ~a, 32'h0000_BEEF};
  endfunction

  // Pushes the port request and, in expected grant order, the scoreboard entry.
  task automatic issue(input int p, input logic [AW-1:0] a, input logic [SW-1:0] s,
                       input logic [BW-1:0] d, input int lat, input bit wig,
                       input logic [AW-1:0] final_a, input logic err);
    req_t r;
    txn_t t;
    r.addr = a; r.wstrb = s; r.wdata = d; r.wiggle = wig;
    pq[p].push_back(r);
    t.port = p; t.addr = final_a; t.wstrb = s; t.wdata = d; t.lat = lat; t.err = err;
    t.rdata = err ? '0 : rdata_for(final_a);
    exp_q.push_back(t);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pq[0].size() == 0 && pq[1].size() == 0) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    chk({tag, "_drain_timeout"}, 256'(exp_q.size()), 256'(0));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: completes each request after mem_lat busy cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '1;
        if (mem_req_valid_o) begin
          if (cnt == mem_lat - 1) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = rdata_for(mem_req_addr_o);
            cnt = 0;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Port driver: holds the head request until accepted; wiggle entries move addr each cycle.
  initial begin
    logic [N-1:0] acc;
    int           pres[N];
    bit           fresh[N];
    for (int p = 0; p < N; p++) begin pres[p] = 0; fresh[p] = 1'b1; end
    wait (drv_en);
    forever begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (acc[p] && pq[p].size() > 0) begin
          void'(pq[p].pop_front());
          fresh[p] = 1'b1;
        end
        if (pq[p].size() > 0) begin
          if (fresh[p]) begin pres[p] = 0; fresh[p] = 1'b0; end
          else if (pq[p][0].wiggle) pres[p]++;
          req_valid_i[p] = 1'b1;
          req_addr_i[p]  = pq[p][0].addr + 32'(4 * pres[p]);
          req_wstrb_i[p] = pq[p][0].wstrb;
          req_wdata_i[p] = pq[p][0].wdata;
        end else begin
          req_valid_i[p] = 1'b0;
          fresh[p]       = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT events against the scoreboard head.
  int              t_grant = 0;
  int              t_mem   = 0;
  logic            prev_mv = 1'b0;
  logic [175:0]    cap     = '0;
  always @(negedge clk) begin
    txn_t         t;
    logic [N-1:0] oh;
    if (!rst_n) begin
      prev_mv = 1'b0;
    end else begin
      if (req_ready_o != '0) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 256'(req_ready_o), 256'(0));
        else begin
          oh = '0; oh[exp_q[0].port] = 1'b1;
          chk("grant", 256'(req_ready_o), 256'(oh));
        end
        t_grant = cyc;
      end
      if (mem_req_valid_o && !prev_mv) begin
        if (exp_q.size() == 0) chk("unexpected_mem_req", 256'(mem_req_valid_o), 256'(0));
        else begin
          chk("mem_addr",  256'(mem_req_addr_o),  256'(exp_q[0].addr));
          chk("mem_wstrb", 256'(mem_req_wstrb_o), 256'(exp_q[0].wstrb));
          chk("mem_wdata", 256'(mem_req_wdata_o), 256'(exp_q[0].wdata));
          chk("accept_to_mem_cycles", 256'(cyc - t_grant), 256'(1));
        end
        t_mem = cyc;
        cap   = {mem_req_addr_o, mem_req_wstrb_o, mem_req_wdata_o};
      end else if (mem_req_valid_o) begin
        chk("mem_req_stable", 256'({mem_req_addr_o, mem_req_wstrb_o, mem_req_wdata_o}), 256'(cap));
      end
      if (res_valid_o != '0) begin
        if (exp_q.size() == 0) chk("unexpected_res", 256'(res_valid_o), 256'(0));
        else begin
          t = exp_q.pop_front();
          oh = '0; oh[t.port] = 1'b1;
          chk("res_valid", 256'(res_valid_o), 256'(oh));
          chk("res_err", 256'(res_err_o), 256'(t.err));
          chk("res_latency", 256'(cyc - t_mem + 1), 256'(t.lat));
          if (t.wstrb == '0) chk("res_rdata", 256'(res_rdata_o), 256'(t.rdata));
        end
      end else begin
        chk("res_idle_zero", 256'({res_err_o, res_rdata_o}), 256'(0));
      end
      prev_mv = mem_req_valid_o;
    end
  end

  initial begin
    bit seen;
    rst_n       = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '1;
    req_valid_i = '1;
    req_addr_i  = {32'h1111_1111, 32'h2222_2222};
    req_wstrb_i = '1;
    req_wdata_i = '1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 256'(req_ready_o), 256'(0));
    chk("rst_res_valid", 256'(res_valid_o), 256'(0));
    chk("rst_res_err",   256'(res_err_o), 256'(0));
    chk("rst_mem_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rst_mem_latch", 256'({mem_req_addr_o, mem_req_wstrb_o, mem_req_wdata_o}), 256'(0));
    req_valid_i = '0;
    rst_n  = 1'b1;
    drv_en = 1'b1;
    mem_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single read on port 1, memory answers in the 4th busy cycle.
    mem_lat = 4;
    issue(1, 32'h8000_0040, '0, {4{32'h5555_AAAA}}, 4, 1'b0, 32'h8000_0040, 1'b0);
    wait_idle("single_read");

    // Both ports held for six transactions: expected grant order 0,1,0,1,0,1.
    mem_lat = 2;
    for (int k = 0; k < 6; k++)
      issue(k % 2, 32'h1000_0000 + 32'(k % 2) * 32'h100 + 32'(k / 2) * 32'h40, '0,
            128'(k), 2, 1'b0, 32'h1000_0000 + 32'(k % 2) * 32'h100 + 32'(k / 2) * 32'h40, 1'b0);
    wait_idle("contention");

    // Port 0 busy for 3 cycles while port 1 moves its address; port 1 is taken at +0x10.
    mem_lat = 3;
    issue(0, 32'h2000_0000, '0, '0, 3, 1'b0, 32'h2000_0000, 1'b0);
    issue(1, 32'h3000_0000, '0, '0, 3, 1'b1, 32'h3000_0010, 1'b0);
    wait_idle("stability");

    // Write forwarding on port 0.
    mem_lat = 5;
    issue(0, 32'h4000_0080, 16'h000F, {96'hA5A5_A5A5_0F0F_0F0F_C3C3_C3C3, 32'h1122_3344},
          5, 1'b0, 32'h4000_0080, 1'b0);
    wait_idle("write");

    // Asynchronous reset in the middle of a busy period.
    mem_en = 1'b0;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    mem_rdata_i = '1;
    @(negedge clk);
    issue(0, 32'h6000_0000, '0, '0, 1, 1'b0, 32'h6000_0000, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req_valid_o;
    end
    chk("rst_busy_reached", 256'(seen), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_valid", 256'(mem_req_valid_o), 256'(0));
    chk("rst_async_req_ready", 256'(req_ready_o), 256'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready_i = 1'b1;
    mem_rdata_i = rdata_for(32'h6000_0000);
    @(negedge clk);
    chk("stale_ready_res_valid", 256'(res_valid_o), 256'(0));
    chk("stale_ready_mem_valid", 256'(mem_req_valid_o), 256'(0));
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    mem_rdata_i = '1;
    mem_en = 1'b1;
    @(negedge clk);

    // After reset last_grant points at the top port, so port 0 wins first.
    mem_lat = 2;
    issue(0, 32'h5000_0000, '0, '0, 2, 1'b0, 32'h5000_0000, 1'b0);
    issue(1, 32'h5000_0100, '0, '0, 2, 1'b0, 32'h5000_0100, 1'b0);
    wait_idle("post_reset_order");

`ifdef MEM_ARB_TIMEOUT_EN
    // No memory answer: forced error completion in busy cycle 8.
    mem_en = 1'b0;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    mem_rdata_i = '1;
    @(negedge clk);
    issue(0, 32'h7000_0000, '0, '0, 8, 1'b0, 32'h7000_0000, 1'b1);
    wait_idle("timeout");
    @(posedge clk); #1;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    repeat (2) @(negedge clk);

    // Answer lands exactly in the expiry cycle: normal completion wins.
    issue(1, 32'h7000_0100, '0, '0, 8, 1'b0, 32'h7000_0100, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req_valid_o;
    end
    chk("tmo_busy_reached", 256'(seen), 256'(1));
    repeat (7) @(posedge clk);
    #1;
    mem_ready_i = 1'b1;
    mem_rdata_i = rdata_for(32'h7000_0100);
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    mem_rdata_i = '1;
    wait_idle("timeout_tie");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
